// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Optional statistics counters are enabled with the ICACHE_STATS_EN macro.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int BLOCK_BITS  = 128;
    localparam int WORD_BITS   = 32;
    localparam int OFFSET_BITS = 4;

    function automatic int tag_width(input int addr_bits, input int index_bits);
        return addr_bits - index_bits - OFFSET_BITS;
    endfunction

endpackage

// File: rtl/icache_if.sv
// CPU-side fetch port and memory-side block-read port of the instruction cache.
interface icache_if import icache_pkg::*; #(
    parameter int ADDR_BITS = 10
);
    // Handshakes: BUSYWAIT is the inverse of ready -- INSTRUCTION is valid for PC
    // in every cycle BUSYWAIT is low, and PC must be held while it is high.
    // MEM_READ is a request held until the first cycle MEM_BUSYWAIT is low;
    // MEM_READDATA is taken in that cycle.
    logic [31:0]                  PC;
    logic [WORD_BITS-1:0]         INSTRUCTION;
    logic                         BUSYWAIT;
    logic                         MEM_READ;
    logic [ADDR_BITS-OFFSET_BITS-1:0] MEM_ADDRESS;
    logic [BLOCK_BITS-1:0]        MEM_READDATA;
    logic                         MEM_BUSYWAIT;

    modport slave (
        input  PC, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    modport master (
        output PC, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one synchronous write port, one combinational read port.
module icache_line_array import icache_pkg::*; #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [BLOCK_BITS-1:0] wr_data,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [BLOCK_BITS-1:0] rd_data
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [BLOCK_BITS-1:0] data_q [LINES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with a 16-byte block refill FSM.
// Defining ICACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT ports.
module icache import icache_pkg::*; #(
    parameter int ADDR_BITS  = 10,
    parameter int INDEX_BITS = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    icache_if.slave     bus,
    output state_t      dbg_state
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);
    localparam int TAG_BITS = tag_width(ADDR_BITS, INDEX_BITS);
    localparam int BLK_BITS = ADDR_BITS - OFFSET_BITS;

    state_t                state_q, state_d;
    logic [BLK_BITS-1:0]   blk_q;
    logic [BLOCK_BITS-1:0] fill_q;
    logic [WORD_BITS-1:0]  instr_q;
    logic                  busy, mem_read;

    logic [BLK_BITS-1:0]   pc_blk;
    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [1:0]            pc_word;
    logic                  pc_unused;

    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [BLOCK_BITS-1:0] rd_data;
    logic                  hit, wr_en;
    logic [WORD_BITS-1:0]  word_sel;

    // PC bits above ADDR_BITS alias by truncation; the byte offset is irrelevant.
    assign pc_blk    = bus.PC[ADDR_BITS-1:OFFSET_BITS];
    assign pc_index  = pc_blk[INDEX_BITS-1:0];
    assign pc_tag    = pc_blk[BLK_BITS-1:INDEX_BITS];
    assign pc_word   = bus.PC[3:2];
    assign pc_unused = ^{bus.PC[31:ADDR_BITS], bus.PC[1:0]};

    // Fills always target the block latched on entry to FETCH, not the live PC.
    assign wr_en = RESET && (state_q == UPDATE);

    icache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_lines (
        .clk      (CLK),
        .rst_n    (RESET),
        .wr_en    (wr_en),
        .wr_index (blk_q[INDEX_BITS-1:0]),
        .wr_tag   (blk_q[BLK_BITS-1:INDEX_BITS]),
        .wr_data  (fill_q),
        .rd_index (pc_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

    assign hit      = rd_valid && (rd_tag == pc_tag);
    assign word_sel = rd_data[{pc_word, 5'b0} +: WORD_BITS];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            blk_q   <= '0;
            fill_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && !hit) blk_q <= pc_blk;
            if (state_q == FETCH && !bus.MEM_BUSYWAIT) fill_q <= bus.MEM_READDATA;
            if (state_q == IDLE && hit) instr_q <= word_sel;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        mem_read = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    busy    = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!bus.MEM_BUSYWAIT) state_d = UPDATE;
            end
            UPDATE: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while RESET is low, independent of state.
    assign bus.BUSYWAIT    = RESET && busy;
    assign bus.MEM_READ    = RESET && mem_read;
    assign bus.MEM_ADDRESS = (RESET && state_q == FETCH) ? blk_q : '0;
    assign bus.INSTRUCTION = !RESET ? '0 :
                             (state_q == IDLE && hit) ? word_sel : instr_q;
    assign dbg_state       = state_q;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else if (state_q == IDLE) begin
            if (hit && HIT_COUNT != 16'hFFFF) HIT_COUNT <= HIT_COUNT + 16'd1;
            if (!hit && MISS_COUNT != 16'hFFFF) MISS_COUNT <= MISS_COUNT + 16'd1;
        end
    end
`endif

endmodule
